// File: rtl/vu_vcu_utm_issue_pkg.sv
// -----------------------------------------------------------------------------
// vu_vcu_utm_issue_pkg
// Shared UT memory interface field sizes and command-class encodings.
// Both this issue stage and the VMU control decoder use them, so the two
// stay in agreement about what a UT memory command looks like.
//   UTMCMD_*   : command queue word = {cmd, vlen}
//   UTMIMM_SZ  : address immediate width
//   UTMRESP_SZ : sync response width (UTMRESP_OK marks a good sync)
// -----------------------------------------------------------------------------
package vu_vcu_utm_issue_pkg;

   localparam int UTMCMD_CMD_SZ  = 8;
   localparam int UTMCMD_VLEN_SZ = 8;
   localparam int UTMCMD_SZ      = UTMCMD_CMD_SZ + UTMCMD_VLEN_SZ;
   localparam int UTMIMM_SZ      = 32;
   localparam int UTMRESP_SZ     = 2;

   // Bit positions inside the command queue word.
   localparam int UTMCMD_VLEN_M1_LSB = 0;
   localparam int UTMCMD_CMDCODE_LSB = UTMCMD_VLEN_M1_LSB + UTMCMD_VLEN_SZ;

   localparam logic [UTMRESP_SZ-1:0] UTMRESP_OK = UTMRESP_SZ'(1'b1);

   // Upper-nibble command groups.
   localparam logic [3:0] UTM_GRP_SYNC  = 4'b0000;
   localparam logic [3:0] UTM_GRP_LOAD  = 4'b1100;
   localparam logic [3:0] UTM_GRP_STORE = 4'b1101;
   localparam logic [3:0] UTM_GRP_AMO0  = 4'b1110;
   localparam logic [3:0] UTM_GRP_AMO1  = 4'b1111;
   // Only the top four codes of the sync group are real sync commands.
   localparam logic [3:0] UTM_SYNC_LO   = 4'd12;

   typedef enum logic [2:0] {
      CLS_INVALID = 3'd0,
      CLS_SYNC    = 3'd1,
      CLS_LOAD    = 3'd2,
      CLS_STORE   = 3'd3,
      CLS_AMO     = 3'd4
   } utm_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_RESP_WAIT = 2'd2
   } utm_state_e;

   function automatic utm_cls_e utm_classify(input logic [UTMCMD_CMD_SZ-1:0] cmd);
      utm_cls_e cls;
      case (cmd[7:4])
         UTM_GRP_SYNC:  cls = (cmd[3:0] >= UTM_SYNC_LO) ? CLS_SYNC : CLS_INVALID;
         UTM_GRP_LOAD:  cls = CLS_LOAD;
         UTM_GRP_STORE: cls = CLS_STORE;
         UTM_GRP_AMO0:  cls = CLS_AMO;
         UTM_GRP_AMO1:  cls = CLS_AMO;
         default:       cls = CLS_INVALID;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/vu_vcu_utm_issue.sv
// -----------------------------------------------------------------------------
// vu_vcu_utm_issue
// Issues decoded UT memory instructions from the vector control unit into the
// UT memory command queue and (for loads/stores) the address immediate queue.
// Sync commands additionally wait for a response from the VMU.
// Ports:
//   clk, reset (async, active-low)
//   in_val/in_rdy/in_cmd/in_vlen/in_addr : incoming decoded instruction
//   utmcmdq_*  : command queue, bits = {cmd, vlen}
//   utmimmq_*  : address immediate queue (LOAD/STORE only)
//   utmrespq_* : sync response from the VMU
//   busy, sync_done (1-cycle pulse), err_invalid / err_resp (sticky),
//   sync_cycles (cycles spent waiting for the last sync response)
// -----------------------------------------------------------------------------
module vu_vcu_utm_issue
   import vu_vcu_utm_issue_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [UTMCMD_CMD_SZ-1:0]  in_cmd,
   input  logic [UTMCMD_VLEN_SZ-1:0] in_vlen,
   input  logic [UTMIMM_SZ-1:0]      in_addr,
   output logic [UTMCMD_SZ-1:0]      utmcmdq_bits,
   output logic                      utmcmdq_val,
   input  logic                      utmcmdq_rdy,
   output logic [UTMIMM_SZ-1:0]      utmimmq_bits,
   output logic                      utmimmq_val,
   input  logic                      utmimmq_rdy,
   input  logic [UTMRESP_SZ-1:0]     utmrespq_bits,
   input  logic                      utmrespq_val,
   output logic                      utmrespq_rdy,
   output logic                      busy,
   output logic                      sync_done,
   output logic                      err_invalid,
   output logic                      err_resp,
   output logic [15:0]               sync_cycles
);

   utm_state_e                state_r;
   utm_state_e                state_nxt_s;
   logic [UTMCMD_CMD_SZ-1:0]  cmd_r;
   logic [UTMCMD_VLEN_SZ-1:0] vlen_r;
   logic [UTMIMM_SZ-1:0]      addr_r;
   logic                      is_sync_r;
   logic                      need_imm_r;
   logic                      cmd_sent_r;
   logic                      imm_sent_r;
   logic                      err_invalid_r;
   logic                      err_resp_r;
   logic                      sync_done_r;
   logic [15:0]               sync_cycles_r;

   utm_cls_e                  in_cls_s;
   logic                      in_fire_s;
   logic                      in_good_s;
   logic                      in_rdy_s;
   logic                      cmd_val_s;
   logic                      imm_val_s;
   logic                      resp_rdy_s;
   logic                      cmd_fire_s;
   logic                      imm_fire_s;
   logic                      resp_fire_s;
   logic                      issue_done_s;

   assign in_cls_s  = utm_classify(in_cmd);
   assign in_fire_s = in_val & in_rdy_s;
   assign in_good_s = (in_cls_s != CLS_INVALID);

   assign cmd_fire_s  = cmd_val_s & utmcmdq_rdy;
   assign imm_fire_s  = imm_val_s & utmimmq_rdy;
   assign resp_fire_s = resp_rdy_s & utmrespq_val;

   // A handshake counts as complete if it already happened or is happening now,
   // so the last one can retire the command in the same cycle.
   assign issue_done_s = (cmd_sent_r | cmd_fire_s) &
                         (~need_imm_r | imm_sent_r | imm_fire_s);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_fire_s && in_good_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (issue_done_s) begin
               state_nxt_s = is_sync_r ? ST_RESP_WAIT : ST_IDLE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_RESP_WAIT: begin
            if (resp_fire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP_WAIT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; all terms come straight from flops, so no input-to-output path.
   always_comb begin
      in_rdy_s   = 1'b0;
      cmd_val_s  = 1'b0;
      imm_val_s  = 1'b0;
      resp_rdy_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            in_rdy_s = 1'b1;
         end
         ST_ISSUE: begin
            cmd_val_s = ~cmd_sent_r;
            imm_val_s = need_imm_r & ~imm_sent_r;
         end
         ST_RESP_WAIT: begin
            resp_rdy_s = 1'b1;
         end
         default: begin
            in_rdy_s = 1'b0;
         end
      endcase
   end

   // Capture the accepted command; held untouched until the next accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_r      <= '0;
         vlen_r     <= '0;
         addr_r     <= '0;
         is_sync_r  <= 1'b0;
         need_imm_r <= 1'b0;
      end else if (in_fire_s && in_good_s) begin
         cmd_r      <= in_cmd;
         vlen_r     <= in_vlen;
         addr_r     <= in_addr;
         is_sync_r  <= (in_cls_s == CLS_SYNC);
         need_imm_r <= (in_cls_s == CLS_LOAD) || (in_cls_s == CLS_STORE);
      end else begin
         cmd_r      <= cmd_r;
         vlen_r     <= vlen_r;
         addr_r     <= addr_r;
         is_sync_r  <= is_sync_r;
         need_imm_r <= need_imm_r;
      end
   end

   // Per-queue sent flags; cleared whenever not issuing so each command starts fresh.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_sent_r <= 1'b0;
         imm_sent_r <= 1'b0;
      end else if (state_r == ST_ISSUE) begin
         cmd_sent_r <= cmd_sent_r | cmd_fire_s;
         imm_sent_r <= imm_sent_r | imm_fire_s;
      end else begin
         cmd_sent_r <= 1'b0;
         imm_sent_r <= 1'b0;
      end
   end

   // Sticky error flags and the sync completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_invalid_r <= 1'b0;
         err_resp_r    <= 1'b0;
         sync_done_r   <= 1'b0;
      end else begin
         err_invalid_r <= err_invalid_r | (in_fire_s & ~in_good_s);
         err_resp_r    <= err_resp_r | (resp_fire_s & (utmrespq_bits != UTMRESP_OK));
         sync_done_r   <= resp_fire_s;
      end
   end

   // Sync latency counter: zeroed on entry to the wait, saturates, holds afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_cycles_r <= 16'd0;
      end else if ((state_r == ST_ISSUE) && (state_nxt_s == ST_RESP_WAIT)) begin
         sync_cycles_r <= 16'd0;
      end else if ((state_r == ST_RESP_WAIT) && (sync_cycles_r != 16'hFFFF)) begin
         sync_cycles_r <= sync_cycles_r + 16'd1;
      end else begin
         sync_cycles_r <= sync_cycles_r;
      end
   end

   assign in_rdy       = in_rdy_s;
   assign utmcmdq_val  = cmd_val_s;
   assign utmcmdq_bits = {cmd_r, vlen_r};
   assign utmimmq_val  = imm_val_s;
   assign utmimmq_bits = addr_r;
   assign utmrespq_rdy = resp_rdy_s;
   assign busy         = (state_r != ST_IDLE);
   assign sync_done    = sync_done_r;
   assign err_invalid  = err_invalid_r;
   assign err_resp     = err_resp_r;
   assign sync_cycles  = sync_cycles_r;

endmodule

// File: tb/tb_vu_vcu_utm_issue.sv
// -----------------------------------------------------------------------------
// tb_vu_vcu_utm_issue
// Directed scenarios plus a randomized run against a transaction-level model
// that counts handshakes per command and tracks the sticky flags.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vu_vcu_utm_issue;
   import vu_vcu_utm_issue_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      in_val;
   logic                      in_rdy;
   logic [UTMCMD_CMD_SZ-1:0]  in_cmd;
   logic [UTMCMD_VLEN_SZ-1:0] in_vlen;
   logic [UTMIMM_SZ-1:0]      in_addr;
   logic [UTMCMD_SZ-1:0]      utmcmdq_bits;
   logic                      utmcmdq_val;
   logic                      utmcmdq_rdy;
   logic [UTMIMM_SZ-1:0]      utmimmq_bits;
   logic                      utmimmq_val;
   logic                      utmimmq_rdy;
   logic [UTMRESP_SZ-1:0]     utmrespq_bits;
   logic                      utmrespq_val;
   logic                      utmrespq_rdy;
   logic                      busy;
   logic                      sync_done;
   logic                      err_invalid;
   logic                      err_resp;
   logic [15:0]               sync_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vu_vcu_utm_issue dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_cmd(in_cmd), .in_vlen(in_vlen), .in_addr(in_addr),
      .utmcmdq_bits(utmcmdq_bits), .utmcmdq_val(utmcmdq_val), .utmcmdq_rdy(utmcmdq_rdy),
      .utmimmq_bits(utmimmq_bits), .utmimmq_val(utmimmq_val), .utmimmq_rdy(utmimmq_rdy),
      .utmrespq_bits(utmrespq_bits), .utmrespq_val(utmrespq_val), .utmrespq_rdy(utmrespq_rdy),
      .busy(busy), .sync_done(sync_done), .err_invalid(err_invalid), .err_resp(err_resp),
      .sync_cycles(sync_cycles)
   );

   // Stimulus only: present one instruction for a single cycle; returns on the
   // falling edge right after the accepting rising edge.
   task automatic accept_cmd(input logic [7:0] c, input logic [7:0] v, input logic [31:0] a);
      @(negedge clk);
      in_val = 1'b1; in_cmd = c; in_vlen = v; in_addr = a;
      @(negedge clk);
      in_val = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_val = 1'b0; in_cmd = 8'h00; in_vlen = 8'h00; in_addr = 32'h0;
      utmcmdq_rdy = 1'b0; utmimmq_rdy = 1'b0; utmrespq_val = 1'b0; utmrespq_bits = 2'd0;
      @(negedge clk);
      n_cmp++;
      if ({in_rdy, utmcmdq_val, utmimmq_val, utmrespq_rdy, busy, sync_done, err_invalid, err_resp} !== 8'b1000_0000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b required 10000000",
                  {in_rdy, utmcmdq_val, utmimmq_val, utmrespq_rdy, busy, sync_done, err_invalid, err_resp});
      end
      n_cmp++;
      if (sync_cycles !== 16'd0) begin
         n_bad++; $display("FAIL reset_sync_cycles: got %0d required 0", sync_cycles);
      end
      reset = 1'b1;
   endtask

   task automatic test_load();
      utmcmdq_rdy = 1'b1; utmimmq_rdy = 1'b1;
      accept_cmd(8'hC0, 8'd7, 32'h1000);
      n_cmp++;
      if ({utmcmdq_val, utmimmq_val, in_rdy} !== 3'b110) begin
         n_bad++; $display("FAIL load_vals: got %b required 110", {utmcmdq_val, utmimmq_val, in_rdy});
      end
      n_cmp++;
      if (utmcmdq_bits !== 16'hC007) begin
         n_bad++; $display("FAIL load_cmd_bits: got %h required c007", utmcmdq_bits);
      end
      n_cmp++;
      if (utmimmq_bits !== 32'h1000) begin
         n_bad++; $display("FAIL load_imm_bits: got %h required 1000", utmimmq_bits);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, in_rdy, utmcmdq_val, utmimmq_val} !== 4'b0100) begin
         n_bad++; $display("FAIL load_idle_after: got %b required 0100", {busy, in_rdy, utmcmdq_val, utmimmq_val});
      end
   endtask

   task automatic test_store();
      int cmd_hs = 0;
      int held = 0;
      logic [31:0] a = $urandom;
      utmcmdq_rdy = 1'b1; utmimmq_rdy = 1'b0;
      accept_cmd(8'hD0, 8'd3, a);
      for (int i = 0; i < 5; i++) begin
         if (utmcmdq_val) cmd_hs++;
         if (utmimmq_val && utmimmq_bits === a) held++;
         if (i == 4) utmimmq_rdy = 1'b1;
         @(negedge clk);
      end
      n_cmp++;
      if (cmd_hs != 1) begin
         n_bad++; $display("FAIL store_cmd_once: got %0d required 1", cmd_hs);
      end
      n_cmp++;
      if (held != 5) begin
         n_bad++; $display("FAIL store_imm_held: got %0d cycles required 5", held);
      end
      n_cmp++;
      if ({busy, utmimmq_val, utmcmdq_val} !== 3'b000) begin
         n_bad++; $display("FAIL store_idle_after: got %b required 000", {busy, utmimmq_val, utmcmdq_val});
      end
   endtask

   task automatic test_amo();
      int cmd_hs = 0;
      int imm_seen = 0;
      utmcmdq_rdy = 1'b0; utmimmq_rdy = 1'b1;
      accept_cmd(8'hE0, 8'd5, 32'hDEAD_BEEF);
      for (int t = 0; t < 10; t++) begin
         if (t == 2) utmcmdq_rdy = 1'b1;
         if (utmimmq_val) imm_seen++;
         if (utmcmdq_val && utmcmdq_rdy) cmd_hs++;
         @(negedge clk);
      end
      n_cmp++;
      if (imm_seen != 0) begin
         n_bad++; $display("FAIL amo_no_imm: got %0d imm cycles required 0", imm_seen);
      end
      n_cmp++;
      if (cmd_hs != 1 || in_rdy !== 1'b1) begin
         n_bad++; $display("FAIL amo_cmd_idle: got hs=%0d in_rdy=%b required hs=1 in_rdy=1", cmd_hs, in_rdy);
      end
   endtask

   task automatic test_sync();
      int t = 0;
      int rdy_high = 0;
      int pulses = 0;
      utmcmdq_rdy = 1'b1; utmimmq_rdy = 1'b1;
      accept_cmd(8'h0C, 8'd0, 32'h0);
      while (utmrespq_rdy !== 1'b1 && t < 20) begin
         if (in_rdy !== 1'b0) rdy_high++;
         @(negedge clk); t++;
      end
      n_cmp++;
      if (t >= 20) begin
         n_bad++; $display("FAIL sync_reach_wait: got no utmrespq_rdy within 20 cycles required wait");
      end
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) begin utmrespq_val = 1'b1; utmrespq_bits = 2'd1; end
         if (in_rdy !== 1'b0) rdy_high++;
         if (sync_done) pulses++;
         @(negedge clk);
      end
      utmrespq_val = 1'b0;
      n_cmp++;
      if (rdy_high != 0) begin
         n_bad++; $display("FAIL sync_in_rdy_low: got %0d cycles with in_rdy high required 0", rdy_high);
      end
      n_cmp++;
      if (sync_cycles !== 16'd10) begin
         n_bad++; $display("FAIL sync_cycles: got %0d required 10", sync_cycles);
      end
      for (int k = 0; k < 3; k++) begin
         if (sync_done) pulses++;
         @(negedge clk);
      end
      n_cmp++;
      if (pulses != 1 || err_resp !== 1'b0) begin
         n_bad++; $display("FAIL sync_done_once: got pulses=%0d err_resp=%b required 1/0", pulses, err_resp);
      end
   endtask

   task automatic test_invalid();
      int vals = 0;
      int t = 0;
      utmcmdq_rdy = 1'b1; utmimmq_rdy = 1'b1;
      accept_cmd(8'h20, 8'd1, 32'h4);
      for (int k = 0; k < 3; k++) begin
         if (utmcmdq_val || utmimmq_val || busy) vals++;
         @(negedge clk);
      end
      n_cmp++;
      if (err_invalid !== 1'b1 || vals != 0) begin
         n_bad++; $display("FAIL invalid_drop: got err_invalid=%b val_cycles=%0d required 1/0", err_invalid, vals);
      end
      accept_cmd(8'h0F, 8'd0, 32'h0);
      while (utmrespq_rdy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      utmrespq_val = 1'b1; utmrespq_bits = 2'd0;
      @(negedge clk);
      utmrespq_val = 1'b0;
      n_cmp++;
      if (err_resp !== 1'b1 || err_invalid !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL invalid_then_bad_resp: got err_resp=%b err_invalid=%b busy=%b required 1/1/0",
                           err_resp, err_invalid, busy);
      end
   endtask

   task automatic test_reset_mid();
      int vals = 0;
      utmcmdq_rdy = 1'b0; utmimmq_rdy = 1'b0;
      accept_cmd(8'hC1, 8'd9, 32'h2000);
      n_cmp++;
      if ({utmcmdq_val, utmimmq_val} !== 2'b11) begin
         n_bad++; $display("FAIL midreset_pre: got %b required 11", {utmcmdq_val, utmimmq_val});
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({utmcmdq_val, utmimmq_val, busy, in_rdy, err_invalid, err_resp} !== 6'b000100) begin
         n_bad++; $display("FAIL midreset_async: got %b required 000100",
                           {utmcmdq_val, utmimmq_val, busy, in_rdy, err_invalid, err_resp});
      end
      @(negedge clk);
      reset = 1'b1; utmcmdq_rdy = 1'b1; utmimmq_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (utmcmdq_val || utmimmq_val || busy) vals++;
      end
      n_cmp++;
      if (vals != 0) begin
         n_bad++; $display("FAIL midreset_no_replay: got %0d active cycles required 0", vals);
      end
   endtask

   task automatic test_random();
      bit ex_err_inv = 0;
      bit ex_err_resp = 0;
      int last_cycles = 0;
      reset = 1'b0; utmrespq_val = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0]  c;
         logic [7:0]  v = 8'($urandom);
         logic [31:0] a = $urandom;
         int hi, lo, kind;
         bit ex_valid, ex_sync, ex_imm, done;
         int cmd_hs = 0, imm_hs = 0, resp_hs = 0, wait_cyc = 0, bad_bits = 0;
         case ($urandom_range(0, 5))
            0: c = 8'h0C + 8'($urandom_range(0, 3));
            1: c = 8'hC0 + 8'($urandom_range(0, 15));
            2: c = 8'hD0 + 8'($urandom_range(0, 15));
            3: c = 8'hE0 + 8'($urandom_range(0, 31));
            4: c = 8'($urandom_range(0, 11));
            default: c = 8'($urandom);
         endcase
         hi = int'(c) / 16; lo = int'(c) % 16;
         kind = (hi == 0 && lo >= 12) ? 1 : (hi == 12 || hi == 13) ? 2 : (hi >= 14) ? 3 : 0;
         ex_valid = (kind != 0); ex_sync = (kind == 1); ex_imm = (kind == 2);
         if (!ex_valid) ex_err_inv = 1;
         accept_cmd(c, v, a);
         done = 0;
         for (int t = 0; t < 200 && !done; t++) begin
            if (in_rdy === 1'b1) begin
               done = 1;
            end else begin
               utmcmdq_rdy = 1'($urandom_range(0, 1));
               utmimmq_rdy = 1'($urandom_range(0, 1));
               utmrespq_val = ($urandom_range(0, 3) == 0);
               utmrespq_bits = 2'($urandom);
               if (utmcmdq_val) begin
                  if (utmcmdq_bits !== {c, v}) bad_bits++;
                  if (utmcmdq_rdy) cmd_hs++;
               end
               if (utmimmq_val) begin
                  if (!ex_imm || utmimmq_bits !== a) bad_bits++;
                  if (utmimmq_rdy) imm_hs++;
               end
               if (utmrespq_rdy) begin
                  wait_cyc++;
                  if (utmrespq_val) begin
                     resp_hs++;
                     if (utmrespq_bits != 2'd1) ex_err_resp = 1;
                  end
               end
               @(negedge clk);
            end
         end
         utmrespq_val = 1'b0;
         if (ex_sync) last_cycles = wait_cyc;
         n_cmp++;
         if (!done) begin
            n_bad++; $display("FAIL rnd_timeout: cmd %h got busy after 200 cycles required idle", c);
         end
         n_cmp++;
         if (cmd_hs != int'(ex_valid) || imm_hs != int'(ex_imm) || resp_hs != int'(ex_sync) || bad_bits != 0) begin
            n_bad++; $display("FAIL rnd_handshakes: cmd %h got cmd=%0d imm=%0d resp=%0d badbits=%0d required %0d/%0d/%0d/0",
                              c, cmd_hs, imm_hs, resp_hs, bad_bits, ex_valid, ex_imm, ex_sync);
         end
         n_cmp++;
         if (sync_done !== 1'(ex_sync) || err_invalid !== 1'(ex_err_inv) || err_resp !== 1'(ex_err_resp)
             || sync_cycles !== 16'(last_cycles)) begin
            n_bad++; $display("FAIL rnd_status: cmd %h got done=%b inv=%b resp=%b cyc=%0d required %b/%b/%b/%0d",
                              c, sync_done, err_invalid, err_resp, sync_cycles, ex_sync, ex_err_inv, ex_err_resp, last_cycles);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_amo();
      test_sync();
      test_invalid();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
